// File: rtl/csr_access_ctrl.sv
// Zicsr initiator: sequences read, modify and write of one CSR operation against a
// CSR file with one-cycle registered read data, returning the old value for rd.
//
// state | meaning
// IDLE  | ready for a new operation, no CSR traffic
// READ  | read address presented; CSR file samples it at the closing edge
// WRITE | old value on csr_rdata_i; modified value written, result captured
module csr_access_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        op_i,
    input  logic [11:0]       csr_addr_i,
    input  logic [XLEN-1:0]   src_i,
    input  logic              src_zero_i,
    input  logic              flush_i,
    output logic              done_o,
    output logic [XLEN-1:0]   rd_data_o,
    output logic [ADDR_W-1:0] csr_raddr_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              csr_we_o,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [XLEN-1:0]   csr_wdata_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] OP_RO = 2'b00;
    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    state_t            state_q, state_d;
    logic [1:0]        op_q;
    logic [11:0]       addr_q;
    logic [XLEN-1:0]   src_q;
    logic              src_zero_q;
    logic              accept;
    logic              finish;

    assign accept = (state_q == IDLE) && req_valid_i && !flush_i;
    assign finish = (state_q == WRITE) && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            src_zero_q <= 1'b0;
            done_o     <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            state_q <= state_d;
            done_o  <= finish;
            if (accept) begin
                op_q       <= op_i;
                addr_q     <= csr_addr_i;
                src_q      <= src_i;
                src_zero_q <= src_zero_i;
            end
            // A flushed operation leaves the previous result visible
            if (finish) begin
                rd_data_o <= csr_rdata_i;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        csr_raddr_o = '0;
        csr_we_o    = 1'b0;
        csr_waddr_o = '0;
        csr_wdata_o = '0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (accept) begin
                    state_d = READ;
                end
            end
            READ: begin
                csr_raddr_o[11:0] = addr_q;
                state_d           = flush_i ? IDLE : WRITE;
            end
            WRITE: begin
                csr_waddr_o[11:0] = addr_q;
                case (op_q)
                    OP_RW:   csr_wdata_o = src_q;
                    OP_RS:   csr_wdata_o = csr_rdata_i | src_q;
                    OP_RC:   csr_wdata_o = csr_rdata_i & ~src_q;
                    default: csr_wdata_o = csr_rdata_i;
                endcase
                // Set/clear with x0/zimm=0 must not write (side-effect-free read)
                csr_we_o = !flush_i &&
                           ((op_q == OP_RW) ||
                            (((op_q == OP_RS) || (op_q == OP_RC)) && !src_zero_q));
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (op_q == OP_RO) begin
            csr_we_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: a small behavioural CSR file with registered read and an
// mcycle counter, directed scenarios plus random operations against an array model.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  op_i;
    logic [11:0] csr_addr_i;
    logic [31:0] src_i;
    logic        src_zero_i;
    logic        flush_i;
    logic        done_o;
    logic [31:0] rd_data_o;
    logic [31:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic        csr_we_o;
    logic [31:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csr_access_ctrl #(.XLEN(32), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_i        (op_i),
        .csr_addr_i  (csr_addr_i),
        .src_i       (src_i),
        .src_zero_i  (src_zero_i),
        .flush_i     (flush_i),
        .done_o      (done_o),
        .rd_data_o   (rd_data_o),
        .csr_raddr_o (csr_raddr_o),
        .csr_rdata_i (csr_rdata_i),
        .csr_we_o    (csr_we_o),
        .csr_waddr_o (csr_waddr_o),
        .csr_wdata_o (csr_wdata_o)
    );

    // CSR file: mapped 0x340..0x343, mcycle at 0xB00 (read-only), anything else reads 0
    logic [31:0] file_mem [4] = '{default: 32'h0};
    logic [31:0] cyc = 32'h0;

    function automatic int csr_idx(input logic [31:0] a);
        if (a[31:12] == 20'h0 && a[11:2] == 10'h0D0) return int'(a[1:0]);
        return -1;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 32'd1;
        if (csr_raddr_o == 32'h0000_0B00)      csr_rdata_i <= cyc;
        else if (csr_idx(csr_raddr_o) >= 0)    csr_rdata_i <= file_mem[csr_idx(csr_raddr_o)];
        else                                   csr_rdata_i <= 32'h0;
        if (csr_we_o && csr_idx(csr_waddr_o) >= 0)
            file_mem[csr_idx(csr_waddr_o)] <= csr_wdata_o;
    end

    // Called at a negedge; returns at the negedge where done_o is seen (or a bound expires)
    task automatic run_op(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                          input logic sz, output logic [31:0] rd, output int lat,
                          output int wes, output logic [31:0] wd, output logic rdy,
                          output logic [31:0] ra);
        req_valid_i = 1'b1;
        op_i        = op;
        csr_addr_i  = addr;
        src_i       = src;
        src_zero_i  = sz;
        rdy         = req_ready_o;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        op_i        = 2'($urandom);
        csr_addr_i  = 12'($urandom);
        src_i       = $urandom;
        src_zero_i  = 1'($urandom);
        lat = 1; wes = 0; wd = 32'h0; rd = 32'hX; ra = csr_raddr_o;
        while (!done_o && lat < 8) begin
            if (csr_we_o) begin
                wes++;
                wd = csr_wdata_o;
            end
            @(negedge clk);
            lat++;
        end
        if (done_o) rd = rd_data_o;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid_i = 1'b0; op_i = 2'b0; csr_addr_i = 12'h0;
        src_i = 32'h0; src_zero_i = 1'b0; flush_i = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({done_o, rd_data_o, csr_we_o, csr_raddr_o, csr_waddr_o, csr_wdata_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: done=%b rd=%h we=%b ra=%h wa=%h wd=%h, want all 0",
                     done_o, rd_data_o, csr_we_o, csr_raddr_o, csr_waddr_o, csr_wdata_o);
        end
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, wd, ra; int lat, wes; logic rdy;
        logic [1:0]  ops  [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] srcs [3] = '{32'hDEADBEEF, 32'h000000F0, 32'h0000000F};
        logic [31:0] olds [3] = '{32'h0, 32'hDEADBEEF, 32'hDEADBEFF};
        logic [31:0] news [3] = '{32'hDEADBEEF, 32'hDEADBEFF, 32'hDEADBEF0};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], 12'h340, srcs[i], 1'b0, rd, lat, wes, wd, rdy, ra);
            total++;
            if (rdy !== 1'b1 || lat != 3 || wes != 1) begin
                bad++;
                $display("FAIL b2b_timing[%0d]: ready=%b lat=%0d we_cycles=%0d want 1/3/1",
                         i, rdy, lat, wes);
            end
            total++;
            if (rd !== olds[i] || wd !== news[i]) begin
                bad++;
                $display("FAIL b2b_data[%0d]: rd=%h wdata=%h want rd=%h wdata=%h",
                         i, rd, wd, olds[i], news[i]);
            end
        end
    endtask

    task automatic test_src_zero();
        logic [31:0] rd, wd, ra; int lat, wes; logic rdy;
        run_op(2'b10, 12'h340, 32'h000000FF, 1'b1, rd, lat, wes, wd, rdy, ra);
        total++;
        if (wes != 0 || lat != 3 || rd !== 32'hDEADBEF0) begin
            bad++;
            $display("FAIL src_zero: we_cycles=%0d lat=%0d rd=%h want 0/3/deadbef0", wes, lat, rd);
        end
    endtask

    task automatic test_mcycle();
        logic [31:0] r1, r2, wd, ra; int lat, wes1, wes2; logic rdy;
        run_op(2'b00, 12'hB00, 32'hFFFFFFFF, 1'b0, r1, lat, wes1, wd, rdy, ra);
        repeat (7) @(negedge clk);
        run_op(2'b00, 12'hB00, 32'hFFFFFFFF, 1'b0, r2, lat, wes2, wd, rdy, ra);
        total++;
        if (wes1 != 0 || wes2 != 0 || (r2 - r1) !== 32'd10) begin
            bad++;
            $display("FAIL mcycle: we_cycles=%0d/%0d delta=%0d want 0/0/10",
                     wes1, wes2, r2 - r1);
        end
    endtask

    task automatic test_flush_read();
        logic [31:0] rd, wd, ra; int lat, wes, dones; logic rdy;
        req_valid_i = 1'b1; op_i = 2'b01; csr_addr_i = 12'h341;
        src_i = 32'h1234; src_zero_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0; flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        wes = 0; dones = 0;
        for (int i = 0; i < 4; i++) begin
            if (csr_we_o) wes++;
            if (done_o) dones++;
            @(negedge clk);
        end
        total++;
        if (wes != 0 || dones != 0) begin
            bad++; $display("FAIL flush_read: we_cycles=%0d dones=%0d want 0/0", wes, dones);
        end
        run_op(2'b00, 12'h341, 32'h0, 1'b0, rd, lat, wes, wd, rdy, ra);
        total++;
        if (rd !== 32'h0 || lat != 3) begin
            bad++; $display("FAIL flush_read_after: rd=%h lat=%0d want 0/3", rd, lat);
        end
    endtask

    task automatic test_flush_idle();
        int dones;
        req_valid_i = 1'b1; op_i = 2'b01; csr_addr_i = 12'h342; src_i = 32'h77;
        flush_i = 1'b1;
        @(negedge clk);
        req_valid_i = 1'b0; flush_i = 1'b0;
        total++;
        if (req_ready_o !== 1'b1 || csr_raddr_o !== 32'h0) begin
            bad++;
            $display("FAIL flush_idle: ready=%b raddr=%h want 1/0", req_ready_o, csr_raddr_o);
        end
        dones = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o || csr_we_o) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL flush_idle_quiet: activity=%0d want 0", dones);
        end
    endtask

    task automatic test_flush_write();
        req_valid_i = 1'b1; op_i = 2'b01; csr_addr_i = 12'h342;
        src_i = 32'hAA; src_zero_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        flush_i = 1'b1;
        #1;
        total++;
        if (csr_we_o !== 1'b0) begin
            bad++; $display("FAIL flush_write_we: got %b want 0", csr_we_o);
        end
        @(negedge clk);
        flush_i = 1'b0;
        total++;
        if (done_o !== 1'b0 || file_mem[2] !== 32'h0) begin
            bad++;
            $display("FAIL flush_write_done: done=%b mem342=%h want 0/0", done_o, file_mem[2]);
        end
    endtask

    task automatic test_reset_mid();
        int act;
        logic we_before;
        req_valid_i = 1'b1; op_i = 2'b01; csr_addr_i = 12'h340;
        src_i = 32'h55; src_zero_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        we_before = csr_we_o;
        rst = 1'b0;
        #1;
        total++;
        if (we_before !== 1'b1) begin
            bad++; $display("FAIL reset_mid_pre: we in WRITE=%b want 1", we_before);
        end
        total++;
        if ({done_o, rd_data_o, csr_we_o, csr_raddr_o, csr_waddr_o, csr_wdata_o} !== '0
            || req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid: done=%b rd=%h we=%b ra=%h wa=%h wd=%h rdy=%b want 0s, rdy 1",
                     done_o, rd_data_o, csr_we_o, csr_raddr_o, csr_waddr_o, csr_wdata_o,
                     req_ready_o);
        end
        @(negedge clk);
        rst = 1'b1;
        act = 0;
        repeat (4) begin
            @(negedge clk);
            if (done_o || csr_we_o) act++;
        end
        total++;
        if (act != 0 || file_mem[0] !== 32'hDEADBEF0 || req_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_after: activity=%0d mem340=%h rdy=%b want 0/deadbef0/1",
                     act, file_mem[0], req_ready_o);
        end
    endtask

    task automatic test_random();
        logic [31:0] ref_mem [4] = '{32'hDEADBEF0, 32'h0, 32'h0, 32'h0};
        logic [11:0] addrs [5] = '{12'h340, 12'h341, 12'h342, 12'h343, 12'h7C0};
        logic [31:0] rd, wd, ra, src, exp_old, exp_new;
        logic [11:0] addr;
        logic [1:0]  op;
        logic        sz, rdy, exp_we;
        int          lat, wes, k, errs;
        errs = 0;
        for (int n = 0; n < 40; n++) begin
            addr = addrs[$urandom_range(0, 4)];
            op   = 2'($urandom);
            src  = $urandom;
            sz   = ($urandom_range(0, 3) == 0);
            k    = csr_idx({20'h0, addr});
            exp_old = (k >= 0) ? ref_mem[k] : 32'h0;
            case (op)
                2'b01:   exp_new = src;
                2'b10:   exp_new = exp_old | src;
                2'b11:   exp_new = exp_old & ~src;
                default: exp_new = exp_old;
            endcase
            exp_we = (op == 2'b01) || (op[1] && !sz);
            if (exp_we && k >= 0) ref_mem[k] = exp_new;
            run_op(op, addr, src, sz, rd, lat, wes, wd, rdy, ra);
            total++;
            if (rd !== exp_old || lat != 3 || wes != int'(exp_we) || rdy !== 1'b1
                || ra !== {20'h0, addr} || (exp_we && wd !== exp_new)) begin
                bad++; errs++;
                if (errs < 6)
                    $display("FAIL random[%0d] op=%0d a=%h: rd=%h lat=%0d we=%0d wd=%h ra=%h want rd=%h lat=3 we=%0d wd=%h",
                             n, op, addr, rd, lat, wes, wd, ra, exp_old, exp_we, exp_new);
            end
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (file_mem[i] !== ref_mem[i]) begin
                bad++;
                $display("FAIL random_final[%0d]: file=%h want %h", i, file_mem[i], ref_mem[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_src_zero();
        test_mcycle();
        test_flush_read();
        test_flush_idle();
        test_flush_write();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Initiator side of the CSR register-file read/write interface.
- Sits in the execute stage. Accepts one Zicsr operation at a time (CSRRW/CSRRS/CSRRC, register or immediate source) and sequences read, modify and write against the CSR file.
- Returns the old CSR value for write-back to rd.
- Accounts for the CSR file's one-cycle registered read latency.

Parameters:
- XLEN, 32, data width of CSR values and operands.
- ADDR_W, 32, width of CSR address buses to the CSR file. Bits [ADDR_W-1:12] are driven zero.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
- req_valid_i  in  1  operation request
- req_ready_o  out  1  high when idle and able to accept
- op_i  in  2  00 read-only, 01 RW, 10 RS (set), 11 RC (clear)
- csr_addr_i  in  12  CSR number
- src_i  in  XLEN  rs1 value or zero-extended zimm
- src_zero_i  in  1  rs1 index / zimm is 0; suppresses write for RS/RC
- flush_i  in  1  pipeline flush, aborts an in-flight operation
- done_o  out  1  one-cycle pulse, rd_data_o valid
- rd_data_o  out  XLEN  old CSR value
- csr_raddr_o  out  ADDR_W  read address to CSR file
- csr_rdata_i  in  XLEN  CSR file read data, valid the cycle after csr_raddr_o is sampled
- csr_we_o  out  1  write enable to CSR file
- csr_waddr_o  out  ADDR_W  write address
- csr_wdata_o  out  XLEN  write data

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE
  - done_o=0, rd_data_o=0
  - latched op/addr/src/src_zero cleared
  - csr_we_o=0, csr_raddr_o=0, csr_waddr_o=0, csr_wdata_o=0
- FSM states:
  - IDLE: req_ready_o=1; csr_raddr_o=0; csr_we_o=0. On req_valid_i & req_ready_o & !flush_i at edge E0: latch op_i, csr_addr_i, src_i, src_zero_i; go to READ.
  - READ: csr_raddr_o={zeros, latched addr}. At edge E1 the CSR file samples the address; go to WRITE. If flush_i in READ: go to IDLE, no write, no done.
  - WRITE: csr_rdata_i holds the old value. Combinationally:
    - csr_waddr_o=latched addr.
    - csr_wdata_o: RW=src; RS=old|src; RC=old&~src; read-only=old.
    - csr_we_o=1 except: op=00; op RS/RC with src_zero=1; or flush_i=1.
    - At edge E2: rd_data_o<=csr_rdata_i; done_o<=!flush_i; go to IDLE.
- done_o is registered. It is high exactly one cycle, the cycle after E2, and is otherwise 0.
- rd_data_o holds its value until the next done_o.
- Latency: accept edge to done_o high = 3 cycles. Throughput: one operation per 3 cycles.
- A new request may be accepted in the same cycle done_o is high.
- Back-to-back operations to the same CSR: the write commits at E2, before the next READ presents its address, so the second operation reads the updated value. No bypass is required.
- csr_we_o is high for at most one cycle per operation and never outside WRITE.
- csr_raddr_o is stable for the whole READ cycle.
- RW with rd=x0 still performs the read. Discarding the result is the pipeline's job.
- Writes to read-only/unknown CSRs (mcycle, mhartid, unmapped) are issued normally. The CSR file ignores them, and rd_data_o returns whatever the file reads (0 for unmapped).
- Reset asserted mid-operation: return immediately to IDLE with all outputs at reset values. No write is issued after reset deasserts.
- flush_i in IDLE blocks acceptance that cycle (req_ready_o stays 1, but no latch).

Test Plan:
- RW 0x340 (mscratch), src=0xDEADBEEF, after reset -> csr_we_o one cycle in WRITE with wdata=0xDEADBEEF; done_o 3 cycles after accept with rd_data_o=0x00000000.
- Then RS 0x340, src=0x000000F0 -> rd_data_o=0xDEADBEEF; wdata=0xDEADBEFF. Then RC 0x340, src=0x0000000F -> rd_data_o=0xDEADBEFF; wdata=0xDEADBEF0. Requests are issued back-to-back on each done_o cycle.
- RS 0x340, src=0x000000FF, src_zero_i=1 -> csr_we_o never asserts; rd_data_o=0xDEADBEF0; done_o pulses.
- Read-only op 0xB00 (mcycle) twice, 10 cycles apart -> csr_we_o stays 0; second rd_data_o minus first rd_data_o = 10.
- flush_i during READ of RW 0x341, src=0x1234 -> no csr_we_o, no done_o; following read of 0x341 returns the prior value.
- rst pulled low during WRITE of RW 0x340, src=0x55 -> outputs immediately 0, state IDLE, req_ready_o=1 after release; no done_o emitted.
